// File: rtl/c_arity123_test.sv
// c_arity123_test: registered ternary demonstrator.
// Three trits arrive as 2-bit pairs and produce three registered results:
// an inverter of A, the modulo-3 sum of A and B, and the median of A, B, C.
// Pair encoding: 01 = 0, 11 = 1, 10 = 2, and 00 is illegal (read as 0).
module c_arity123_test (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] io_in,
  output logic [5:0] io_out
);

  // Values after decoding are held as plain binary 0..2 on 2 bits
  logic [1:0] val_a;
  logic [1:0] val_b;
  logic [1:0] val_c;
  logic [1:0] y1_val;
  logic [1:0] y2_val;
  logic [1:0] y3_val;
  logic [2:0] sum_ab;
  logic [5:0] next_out;

  // Map a wire pair to its value; the illegal 00 pattern falls into logic 0
  function automatic logic [1:0] decode_trit(input logic [1:0] pair);
    logic [1:0] v;
    case (pair)
      2'b11:   v = 2'd1;
      2'b10:   v = 2'd2;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  // Map a value back to its wire pair; never produces 00
  function automatic logic [1:0] encode_trit(input logic [1:0] v);
    logic [1:0] pair;
    case (v)
      2'd1:    pair = 2'b11;
      2'd2:    pair = 2'b10;
      default: pair = 2'b01;
    endcase
    return pair;
  endfunction

  // Decode the three input pairs
  always_comb begin
    val_a = decode_trit(io_in[5:4]);
    val_b = decode_trit(io_in[3:2]);
    val_c = decode_trit(io_in[1:0]);
  end

  // Inverter and modulo-3 sum; sum of two values is at most 4, so one
  // conditional subtraction folds it back into range
  always_comb begin
    y1_val = 2'd2 - val_a;
    sum_ab = {1'b0, val_a} + {1'b0, val_b};
    if (sum_ab >= 3'd3) begin
      y2_val = 2'(sum_ab - 3'd3);
    end else begin
      y2_val = sum_ab[1:0];
    end
  end

  // Median of three by pairwise comparison; ties naturally yield the
  // repeated value, which is the majority result
  always_comb begin
    if (val_a >= val_b) begin
      if (val_b >= val_c) begin
        y3_val = val_b;
      end else if (val_a >= val_c) begin
        y3_val = val_c;
      end else begin
        y3_val = val_a;
      end
    end else begin
      if (val_a >= val_c) begin
        y3_val = val_a;
      end else if (val_b >= val_c) begin
        y3_val = val_c;
      end else begin
        y3_val = val_b;
      end
    end
  end

  // Re-encode the three results into the output bus layout
  always_comb begin
    next_out = {encode_trit(y1_val), encode_trit(y2_val), encode_trit(y3_val)};
  end

  // Output register; reset loads all-zero trits (01 pairs), not all-zero bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_out <= 6'h15;
    end else begin
      io_out <= next_out;
    end
  end

endmodule

// File: tb/tb_c_arity123_test.sv
// tb_c_arity123_test: self-checking bench for c_arity123_test.
// Expected outputs come from an arithmetic model of the ternary functions.
module tb_c_arity123_test;

  logic       clk;
  logic       rst_n;
  logic [5:0] io_in;
  logic [5:0] io_out;

  int checks;
  int failures;

  c_arity123_test dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_in  (io_in),
    .io_out (io_out)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pair to integer value; illegal 00 reads as 0
  function automatic int tri_val(input logic [1:0] pair);
    if (pair == 2'b11) return 1;
    if (pair == 2'b10) return 2;
    return 0;
  endfunction

  // Integer value to pair
  function automatic logic [1:0] tri_pair(input int v);
    if (v == 1) return 2'b11;
    if (v == 2) return 2'b10;
    return 2'b01;
  endfunction

  // Reference: inverter, mod-3 sum, median as sum minus max minus min
  function automatic logic [5:0] model(input logic [5:0] x);
    int a, b, c, mx, mn, y1, y2, y3;
    a  = tri_val(x[5:4]);
    b  = tri_val(x[3:2]);
    c  = tri_val(x[1:0]);
    mx = (a > b) ? a : b;
    mx = (mx > c) ? mx : c;
    mn = (a < b) ? a : b;
    mn = (mn < c) ? mn : c;
    y1 = 2 - a;
    y2 = (a + b) % 3;
    y3 = a + b + c - mx - mn;
    return {tri_pair(y1), tri_pair(y2), tri_pair(y3)};
  endfunction

  function automatic logic has_zero_pair(input logic [5:0] v);
    return (v[5:4] == 2'b00) || (v[3:2] == 2'b00) || (v[1:0] == 2'b00);
  endfunction

  task automatic check_output(input string tag, input logic [5:0] got,
                              input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive one input for one edge, then check the registered result
  task automatic apply_stimulus(input string tag, input logic [5:0] x,
                                input logic rst_val);
    logic [5:0] exp;
    @(negedge clk);
    io_in = x;
    rst_n = rst_val;
    @(posedge clk);
    #1;
    exp = rst_val ? model(x) : 6'h15;
    check_output(tag, io_out, exp);
    check_output({tag, "_no00"}, {5'd0, has_zero_pair(io_out)}, 6'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    io_in    = 6'h2B;

    // Reset held two cycles with a nonzero input
    apply_stimulus("reset0", 6'h2B, 1'b0);
    apply_stimulus("reset1", 6'h2B, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    io_in = 6'h15;
    #1;
    check_output("reset_release_hold", io_out, 6'h15);

    // Directed cases with hand-derived expectations
    @(posedge clk);
    #1;
    check_output("dir_a0b0c0", io_out, 6'b100101);
    apply_stimulus("dir_a1b0c0", 6'h35, 1'b1);
    check_output("dir_a1b0c0_const", io_out, 6'b111101);
    apply_stimulus("dir_a2b2c1", 6'h2B, 1'b1);
    check_output("dir_a2b2c1_const", io_out, 6'b011110);
    apply_stimulus("dir_a2b1c2", 6'h2E, 1'b1);
    check_output("dir_a2b1c2_const", io_out, 6'b010110);
    apply_stimulus("illegal_all00", 6'h00, 1'b1);
    check_output("illegal_all00_const", io_out, 6'b100101);

    // Exhaustive legal sweep, one combination per cycle
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 3; b++) begin
        for (int c = 0; c < 3; c++) begin
          apply_stimulus("sweep", {tri_pair(a), tri_pair(b), tri_pair(c)}, 1'b1);
        end
      end
    end

    // Mid-operation reset discards the pending result
    apply_stimulus("mid_reset", 6'h2E, 1'b0);
    apply_stimulus("after_reset", 6'h3A, 1'b1);

    // Random inputs including illegal pairs, with occasional resets
    for (int i = 0; i < 300; i++) begin
      logic [5:0] r;
      logic       rr;
      r  = 6'($urandom_range(0, 63));
      rr = ($urandom_range(0, 15) != 0);
      apply_stimulus("random", r, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
